umi_demux_reg: RTL and testbench



---
 rtl/umi_demux_reg.sv | 92 +++++++++
 tb/tb_umi_demux_reg.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_demux_reg.sv
// Registered 1-to-N UMI request demultiplexer: decodes a lane from a dstaddr bit field and
// holds each routed beat in a per-lane valid/ready output register.
module umi_demux_reg #(
  parameter int unsigned N      = 4,
  parameter int unsigned CW     = 32,
  parameter int unsigned AW     = 64,
  parameter int unsigned DW     = 256,
  parameter int unsigned SELLSB = 40
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            umi_in_valid,
  input  logic [CW-1:0]   umi_in_cmd,
  input  logic [AW-1:0]   umi_in_dstaddr,
  input  logic [AW-1:0]   umi_in_srcaddr,
  input  logic [DW-1:0]   umi_in_data,
  output logic            umi_in_ready,
  output logic [N-1:0]    umi_out_valid,
  output logic [N*CW-1:0] umi_out_cmd,
  output logic [N*AW-1:0] umi_out_dstaddr,
  output logic [N*AW-1:0] umi_out_srcaddr,
  output logic [N*DW-1:0] umi_out_data,
  input  logic [N-1:0]    umi_out_ready,
  output logic            err_drop
);

  localparam int unsigned SelW = $clog2(N);

  logic [SelW-1:0] sel;
  logic [N-1:0]    hit;
  logic [N-1:0]    lane_open;
  logic [N-1:0]    cap;
  logic [N-1:0]    valid_q, valid_d;
  logic            in_range;
  logic            accept;
  logic            err_drop_q;

  logic [N*CW-1:0] cmd_q;
  logic [N*AW-1:0] dst_q;
  logic [N*AW-1:0] src_q;
  logic [N*DW-1:0] data_q;

  assign sel       = umi_in_dstaddr[SELLSB +: SelW];
  assign lane_open = ~valid_q | umi_out_ready;

  // An out-of-range select matches no lane, so ready stays 1 and the beat is swallowed.
  always_comb begin
    hit          = '0;
    umi_in_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel == SelW'(i)) begin
        hit[i]       = 1'b1;
        umi_in_ready = lane_open[i];
      end
    end
  end

  assign in_range = |hit;
  assign accept   = umi_in_valid & umi_in_ready;
  assign cap      = {N{accept}} & hit;
  assign valid_d  = cap | (valid_q & ~umi_out_ready);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q    <= '0;
      err_drop_q <= 1'b0;
      cmd_q      <= '0;
      dst_q      <= '0;
      src_q      <= '0;
      data_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      err_drop_q <= accept & ~in_range;
      for (int i = 0; i < N; i++) begin
        if (cap[i]) begin
          cmd_q[i*CW +: CW]  <= umi_in_cmd;
          dst_q[i*AW +: AW]  <= umi_in_dstaddr;
          src_q[i*AW +: AW]  <= umi_in_srcaddr;
          data_q[i*DW +: DW] <= umi_in_data;
        end
      end
    end
  end

  assign umi_out_valid   = valid_q;
  assign umi_out_cmd     = cmd_q;
  assign umi_out_dstaddr = dst_q;
  assign umi_out_srcaddr = src_q;
  assign umi_out_data    = data_q;
  assign err_drop        = err_drop_q;

endmodule

// File: tb/tb_umi_demux_reg.sv
// Bench for umi_demux_reg: directed scenario tasks plus a randomized run, all checked against
// a per-lane queue model of accepted-but-undelivered beats.
module tb_umi_demux_reg;

  localparam int unsigned CW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 256;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk;
  logic            nreset;
  logic            umi_in_valid;
  logic [CW-1:0]   umi_in_cmd;
  logic [AW-1:0]   umi_in_dstaddr;
  logic [AW-1:0]   umi_in_srcaddr;
  logic [DW-1:0]   umi_in_data;
  logic            umi_in_ready;
  logic [3:0]      umi_out_valid;
  logic [4*CW-1:0] umi_out_cmd;
  logic [4*AW-1:0] umi_out_dstaddr;
  logic [4*AW-1:0] umi_out_srcaddr;
  logic [4*DW-1:0] umi_out_data;
  logic [3:0]      umi_out_ready;
  logic            err_drop;

  // Three-lane instance for the out-of-range select case; shares the payload inputs.
  logic            v3;
  logic            in_ready3;
  logic [2:0]      valid3;
  logic [3*CW-1:0] cmd3;
  logic [3*AW-1:0] dst3;
  logic [3*AW-1:0] src3;
  logic [3*DW-1:0] data3;
  logic [2:0]      ready3;
  logic            err3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  beat_t lq[4][$];
  bit    drop_pend;

  umi_demux_reg #(.N(4), .CW(CW), .AW(AW), .DW(DW), .SELLSB(40)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .err_drop        (err_drop)
  );

  umi_demux_reg #(.N(3), .CW(CW), .AW(AW), .DW(DW), .SELLSB(40)) dut3 (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (v3),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (in_ready3),
    .umi_out_valid   (valid3),
    .umi_out_cmd     (cmd3),
    .umi_out_dstaddr (dst3),
    .umi_out_srcaddr (src3),
    .umi_out_data    (data3),
    .umi_out_ready   (ready3),
    .err_drop        (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: a lane is expected valid exactly while its queue holds an undelivered beat.
  always @(negedge clk) begin : monitor
    int    s;
    bit    exp_rdy;
    beat_t got;
    if (!nreset) begin
      total_cnt++;
      if (umi_out_valid !== 4'b0000 || err_drop !== 1'b0)
        $display("FAIL mon_reset valid=%b err_drop=%b required valid=0000 err_drop=0",
                 umi_out_valid, err_drop);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) lq[i].delete();
      drop_pend = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        total_cnt++;
        if (umi_out_valid[i] !== (lq[i].size() > 0))
          $display("FAIL mon_valid lane=%0d got=%b required=%b", i, umi_out_valid[i],
                   lq[i].size() > 0);
        else pass_cnt++;
        if (lq[i].size() > 0 && umi_out_valid[i] === 1'b1) begin
          got = {umi_out_cmd[i*CW +: CW], umi_out_dstaddr[i*AW +: AW],
                 umi_out_srcaddr[i*AW +: AW], umi_out_data[i*DW +: DW]};
          total_cnt++;
          if (got !== lq[i][0])
            $display("FAIL mon_payload lane=%0d got data=%h required data=%h", i,
                     got.data, lq[i][0].data);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (err_drop !== drop_pend)
        $display("FAIL mon_err_drop got=%b required=%b", err_drop, drop_pend);
      else pass_cnt++;
      s       = int'(umi_in_dstaddr[41:40]);
      exp_rdy = (lq[s].size() == 0) || (umi_out_ready[s] === 1'b1);
      total_cnt++;
      if (umi_in_ready !== exp_rdy)
        $display("FAIL mon_in_ready sel=%0d got=%b required=%b", s, umi_in_ready, exp_rdy);
      else pass_cnt++;
      for (int i = 0; i < 4; i++)
        if (lq[i].size() > 0 && umi_out_ready[i] === 1'b1) void'(lq[i].pop_front());
      drop_pend = 1'b0;
      if (umi_in_valid === 1'b1 && exp_rdy)
        lq[s].push_back({umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data});
    end
  end

  task automatic set_req(input int s, input logic [DW-1:0] d);
    logic [AW-1:0] a;
    a             = {$urandom, $urandom};
    a[41:40]      = 2'(s);
    umi_in_dstaddr = a;
    umi_in_cmd     = $urandom;
    umi_in_srcaddr = {$urandom, $urandom};
    umi_in_data    = d;
  endtask

  task automatic send(input int s, input logic [DW-1:0] d);
    int n = 0;
    set_req(s, d);
    umi_in_valid = 1'b1;
    @(negedge clk);
    while (umi_in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (umi_in_ready !== 1'b1) $display("FAIL send_timeout lane=%0d ready=%b required=1", s,
                                        umi_in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    umi_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total_cnt++;
    if (umi_out_valid !== 4'b0000 || err_drop !== 1'b0 || umi_in_ready !== 1'b1 ||
        umi_out_data !== '0)
      $display("FAIL reset_state valid=%b err=%b ready=%b required 0000/0/1",
               umi_out_valid, err_drop, umi_in_ready);
    else pass_cnt++;
    idle(2);
    nreset = 1'b1;
    idle(2);
    umi_out_ready = 4'b0000;
    send(0, 256'h11);
    send(2, 256'h22);
    total_cnt++;
    if (umi_out_valid !== 4'b0101) $display("FAIL reset_prefill got=%b required=0101",
                                            umi_out_valid);
    else pass_cnt++;
    nreset = 1'b0;
    #1;
    total_cnt++;
    if (umi_out_valid !== 4'b0000 || umi_in_ready !== 1'b1)
      $display("FAIL reset_async valid=%b ready=%b required 0000/1", umi_out_valid, umi_in_ready);
    else pass_cnt++;
    idle(1);
    nreset        = 1'b1;
    umi_out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      total_cnt++;
      if (umi_out_valid !== 4'b0000) $display("FAIL reset_spurious got=%b required=0000",
                                              umi_out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_single;
    umi_out_ready = 4'b1111;
    send(2, 256'hA5);
    total_cnt++;
    if (umi_out_valid !== 4'b0100 || umi_out_data[2*DW +: DW] !== 256'hA5)
      $display("FAIL single_route valid=%b data=%h required 0100/a5", umi_out_valid,
               umi_out_data[2*DW +: DW]);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (umi_out_valid !== 4'b0000) $display("FAIL single_once got=%b required=0000",
                                            umi_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    umi_out_ready = 4'b1101;
    send(1, 256'hD1);
    set_req(1, 256'hD2);
    umi_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++;
      if (umi_in_ready !== 1'b0 || umi_out_data[DW +: DW] !== 256'hD1 || umi_out_valid[1] !== 1)
        $display("FAIL bp_stall ready=%b data=%h required 0/d1", umi_in_ready,
                 umi_out_data[DW +: DW]);
      else pass_cnt++;
      idle(1);
    end
    umi_out_ready = 4'b1111;
    #1;
    total_cnt++;
    if (umi_in_ready !== 1'b1) $display("FAIL bp_release ready=%b required=1", umi_in_ready);
    else pass_cnt++;
    idle(1);
    umi_in_valid = 1'b0;
    total_cnt++;
    if (umi_out_valid[1] !== 1'b1 || umi_out_data[DW +: DW] !== 256'hD2)
      $display("FAIL bp_swap valid=%b data=%h required 1/d2", umi_out_valid[1],
               umi_out_data[DW +: DW]);
    else pass_cnt++;
    idle(1);
  endtask

  task automatic test_back_to_back;
    umi_out_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      set_req(3, DW'(100 + k));
      umi_in_valid = 1'b1;
      idle(1);
      total_cnt++;
      if (umi_out_valid[3] !== 1'b1 || umi_out_data[3*DW +: DW] !== DW'(100 + k))
        $display("FAIL b2b_beat k=%0d valid=%b data=%h required 1/%0d", k, umi_out_valid[3],
                 umi_out_data[3*DW +: DW], 100 + k);
      else pass_cnt++;
    end
    umi_in_valid = 1'b0;
    idle(1);
    total_cnt++;
    if (umi_out_valid !== 4'b0000) $display("FAIL b2b_end got=%b required=0000", umi_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_head_of_line;
    umi_out_ready = 4'b1010;
    send(2, 256'h6);
    send(0, 256'hA);
    set_req(0, 256'hB);
    umi_in_valid  = 1'b1;
    umi_out_ready = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (umi_in_ready !== 1'b0 || umi_out_valid[1] !== 1'b0 || umi_out_data[DW-1:0] !== 256'hA)
        $display("FAIL hol_block ready=%b valid=%b required ready=0 lane1=0", umi_in_ready,
                 umi_out_valid);
      else pass_cnt++;
      idle(1);
    end
    total_cnt++;
    if (umi_out_valid !== 4'b0001) $display("FAIL hol_drain got=%b required=0001",
                                            umi_out_valid);
    else pass_cnt++;
    umi_out_ready = 4'b1111;
    idle(1);
    set_req(1, 256'hC);
    total_cnt++;
    if (umi_out_valid !== 4'b0001 || umi_out_data[DW-1:0] !== 256'hB)
      $display("FAIL hol_unblock valid=%b data=%h required 0001/b", umi_out_valid,
               umi_out_data[DW-1:0]);
    else pass_cnt++;
    idle(1);
    umi_in_valid = 1'b0;
    total_cnt++;
    if (umi_out_valid !== 4'b0010 || umi_out_data[DW +: DW] !== 256'hC)
      $display("FAIL hol_next valid=%b data=%h required 0010/c", umi_out_valid,
               umi_out_data[DW +: DW]);
    else pass_cnt++;
    idle(1);
  endtask

  task automatic test_out_of_range;
    ready3 = 3'b000;
    set_req(0, 256'h55);
    v3 = 1'b1;
    idle(1);
    v3 = 1'b0;
    set_req(3, 256'h77);
    v3 = 1'b1;
    #1;
    total_cnt++;
    if (in_ready3 !== 1'b1 || valid3 !== 3'b001)
      $display("FAIL oor_ready ready=%b valid=%b required 1/001", in_ready3, valid3);
    else pass_cnt++;
    idle(1);
    v3 = 1'b0;
    total_cnt++;
    if (err3 !== 1'b1 || valid3 !== 3'b001 || data3[DW-1:0] !== 256'h55)
      $display("FAIL oor_drop err=%b valid=%b required 1/001", err3, valid3);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (err3 !== 1'b0 || valid3 !== 3'b001)
      $display("FAIL oor_pulse err=%b valid=%b required 0/001", err3, valid3);
    else pass_cnt++;
    ready3 = 3'b111;
    idle(1);
  endtask

  task automatic test_random;
    bit hs;
    logic [DW-1:0] d;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs = umi_in_valid && umi_in_ready;
      @(posedge clk);
      #1;
      umi_out_ready = 4'($urandom);
      if (!umi_in_valid || hs) begin
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        set_req(int'($urandom_range(0, 3)), d);
        umi_in_valid = ($urandom_range(0, 9) < 7);
      end
    end
    umi_in_valid  = 1'b0;
    umi_out_ready = 4'b1111;
    idle(3);
  endtask

  initial begin
    nreset         = 1'b0;
    umi_in_valid   = 1'b0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = 4'b1111;
    v3             = 1'b0;
    ready3         = 3'b111;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_head_of_line();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
